// File: rtl/mac_seq_controller.sv
// Sequencing controller for a complex multiply-accumulate datapath.
// For each operation it loads the operands, then for every term issues the
// multiplier, waits for its result and adds it into the accumulator.
// All outputs are decoded from registered state only (Moore machine).
module mac_seq_controller #(
    parameter int N_TERMS = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             accumulate,
    input  logic             abort,
    input  logic             CMReady,
    output logic             ldArgs,
    output logic             init0Acc,
    output logic [IDX_W-1:0] seli,
    output logic             CMStart,
    output logic             ldAcc,
    output logic             ready,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_e;

    // Index of the final term; the counter stops here instead of wrapping.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             acc_mode_q, acc_mode_d;

    // State, term counter and captured accumulate mode; async reset to idle.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            acc_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_mode_q <= acc_mode_d;
        end
    end

    // Next-state logic: abort overrides every other transition.
    // NOTE: every variable gets a hold default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_mode_d = acc_mode_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_LOAD;
                        acc_mode_d = accumulate;
                    end
                end
                S_LOAD: begin
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (CMReady) begin
                        state_d = S_ACC;
                    end
                end
                S_ACC: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state, counter and mode flag.
    always_comb begin
        ldArgs   = 1'b0;
        init0Acc = 1'b0;
        seli     = '0;
        CMStart  = 1'b0;
        ldAcc    = 1'b0;
        ready    = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_LOAD: begin
                ldArgs   = 1'b1;
                init0Acc = ~acc_mode_q;
            end
            S_ISSUE: begin
                CMStart = 1'b1;
                seli    = idx_q;
            end
            S_WAIT: begin
                seli = idx_q;
            end
            S_ACC: begin
                ldAcc = 1'b1;
                seli  = idx_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_seq_controller.sv
// Self-checking bench: three controller instances (4, 5 and 1 terms) share
// one stimulus stream and are compared every cycle against a cycle-level
// reference model, plus a vector table and directed corner sequences.
module tb_mac_seq_controller;

    logic clk, rst, start, accumulate, abort, CMReady;

    logic       rd4, la4, i04, cs4, lc4, dn4;
    logic [1:0] sl4;
    logic       rd5, la5, i05, cs5, lc5, dn5;
    logic [2:0] sl5;
    logic       rd1, la1, i01, cs1, lc1, dn1;
    logic [0:0] sl1;

    mac_seq_controller #(.N_TERMS(4), .IDX_W(2)) dut4 (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .abort(abort), .CMReady(CMReady), .ldArgs(la4), .init0Acc(i04),
        .seli(sl4), .CMStart(cs4), .ldAcc(lc4), .ready(rd4), .done(dn4));

    mac_seq_controller #(.N_TERMS(5), .IDX_W(3)) dut5 (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .abort(abort), .CMReady(CMReady), .ldArgs(la5), .init0Acc(i05),
        .seli(sl5), .CMStart(cs5), .ldAcc(lc5), .ready(rd5), .done(dn5));

    mac_seq_controller #(.N_TERMS(1), .IDX_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .abort(abort), .CMReady(CMReady), .ldArgs(la1), .init0Acc(i01),
        .seli(sl1), .CMStart(cs1), .ldAcc(lc1), .ready(rd1), .done(dn1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: busy flag, term number (-1 = operand load cycle),
    // sub-step inside a term (0 issue, 1 waiting, 2 accumulate), finish flag.
    int m_n[3] = '{4, 5, 1};
    bit m_busy[3];
    int m_t[3];
    int m_sub[3];
    bit m_fin[3];
    bit m_acc[3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 1'b0; m_t[k] = 0; m_sub[k] = 0; m_fin[k] = 1'b0; m_acc[k] = 1'b0;
        end
    endtask

    // Vector layout: {ready, ldArgs, init0Acc, CMStart, ldAcc, done, seli[7:0]}
    function automatic logic [13:0] exp_vec(int k);
        logic [13:0] v;
        v = '0;
        if (!m_busy[k]) v[13] = 1'b1;
        else if (m_fin[k]) v[8] = 1'b1;
        else if (m_t[k] < 0) begin
            v[12] = 1'b1;
            v[11] = !m_acc[k];
        end else begin
            v[7:0] = 8'(m_t[k]);
            if (m_sub[k] == 0) v[10] = 1'b1;
            if (m_sub[k] == 2) v[9] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [13:0] dut_vec(int k);
        logic [13:0] v;
        case (k)
            0:       v = {rd4, la4, i04, cs4, lc4, dn4, 8'(sl4)};
            1:       v = {rd5, la5, i05, cs5, lc5, dn5, 8'(sl5)};
            default: v = {rd1, la1, i01, cs1, lc1, dn1, 8'(sl1)};
        endcase
        return v;
    endfunction

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            if (abort) m_busy[k] = 1'b0;
            else if (!m_busy[k]) begin
                if (start) begin
                    m_busy[k] = 1'b1; m_t[k] = -1; m_fin[k] = 1'b0; m_acc[k] = accumulate;
                end
            end else if (m_fin[k]) m_busy[k] = 1'b0;
            else if (m_t[k] < 0) begin
                m_t[k] = 0; m_sub[k] = 0;
            end else if (m_sub[k] == 0) m_sub[k] = 1;
            else if (m_sub[k] == 1) begin
                if (CMReady) m_sub[k] = 2;
            end else if (m_t[k] == m_n[k] - 1) m_fin[k] = 1'b1;
            else begin
                m_t[k]++; m_sub[k] = 0;
            end
        end
    endtask

    int cyc = 0;

    task automatic tick_check();
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("model cyc%0d n%0d", cyc, m_n[k]), 32'(dut_vec(k)), 32'(exp_vec(k)));
    endtask

    task automatic tick_adv();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic cycle();
        tick_check();
        tick_adv();
    endtask

    // One abort cycle returns every instance to idle.
    task automatic drain();
        start = 1'b0; abort = 1'b1; CMReady = 1'b0;
        cycle();
        abort = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic st, ac, ab, cr;
        logic rdy, lda, i0, cms, lac, dn;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl[17];
    int   n_lc, n_dn, done_c, max_sel, n_i0;
    int   cs_q[$];
    int   lc_q[$];

    initial begin
        // idle with CMReady high, start, LOAD, then four terms with CMReady
        // held high (it must not skip WAIT), DONE, back to ready
        tbl[0]  = '{0,0,0,1, 1,0,0,0,0,0, 2'd0};
        tbl[1]  = '{1,0,0,1, 1,0,0,0,0,0, 2'd0};
        tbl[2]  = '{0,0,0,1, 0,1,1,0,0,0, 2'd0};
        for (int t = 0; t < 4; t++) begin
            tbl[3 + 3*t] = '{0,0,0,1, 0,0,0,1,0,0, 2'(t)};
            tbl[4 + 3*t] = '{0,0,0,1, 0,0,0,0,0,0, 2'(t)};
            tbl[5 + 3*t] = '{0,0,0,1, 0,0,0,0,1,0, 2'(t)};
        end
        tbl[15] = '{0,0,0,0, 0,0,0,0,0,1, 2'd0};
        tbl[16] = '{0,0,0,0, 1,0,0,0,0,0, 2'd0};

        rst = 1'b1; start = 1'b0; accumulate = 1'b0; abort = 1'b0; CMReady = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_ready", 32'(rd4), 32'd1);
        check("reset_outs", 32'({la4, i04, cs4, lc4, dn4, sl4}), 32'd0);
        rst = 1'b0;

        // Table run on the 4-term instance (start is row 1 = cycle 0).
        for (int i = 0; i < 17; i++) begin
            start = tbl[i].st; accumulate = tbl[i].ac; abort = tbl[i].ab; CMReady = tbl[i].cr;
            tick_check();
            check($sformatf("tbl row%0d", i),
                  32'({rd4, la4, i04, cs4, lc4, dn4, sl4}),
                  32'({tbl[i].rdy, tbl[i].lda, tbl[i].i0, tbl[i].cms, tbl[i].lac, tbl[i].dn, tbl[i].sel}));
            if (i == 6) check("n1_done_cycle5", 32'(dn1), 32'd1);
            tick_adv();
        end
        drain();

        // Accumulate mode, CMReady on the third WAIT cycle of each term.
        n_i0 = 0; done_c = -1; cs_q.delete(); lc_q.delete();
        for (int c = 0; c < 24; c++) begin
            start = (c == 0); accumulate = 1'b1; CMReady = (c > 0 && c % 5 == 0);
            tick_check();
            if (cs4) cs_q.push_back(c);
            if (lc4) lc_q.push_back(c);
            if (i04) n_i0++;
            if (dn4) done_c = c;
            tick_adv();
        end
        check("acc_init0_count", 32'(n_i0), 32'd0);
        check("acc_cmstart_n", 32'(cs_q.size()), 32'd4);
        check("acc_ldacc_n", 32'(lc_q.size()), 32'd4);
        for (int t = 0; t < 4 && t < cs_q.size() && t < lc_q.size(); t++) begin
            check($sformatf("acc_cmstart%0d", t), 32'(cs_q[t]), 32'(2 + 5*t));
            check($sformatf("acc_ldacc%0d", t), 32'(lc_q[t]), 32'(6 + 5*t));
        end
        check("acc_done_cycle", 32'(done_c), 32'd22);
        drain();

        // Abort in the second WAIT with CMReady also high: abort wins.
        n_lc = 0; n_dn = 0;
        for (int c = 0; c < 14; c++) begin
            start = (c == 0); accumulate = 1'b0;
            CMReady = (c == 3 || c == 6); abort = (c == 6);
            tick_check();
            if (lc4) n_lc++;
            if (dn4) n_dn++;
            if (c == 7) check("abort_ready_next", 32'(rd4), 32'd1);
            tick_adv();
        end
        abort = 1'b0;
        check("abort_ldacc_count", 32'(n_lc), 32'd1);
        check("abort_no_done", 32'(n_dn), 32'd0);
        for (int c = 0; c < 5; c++) begin
            start = (c == 0); CMReady = 1'b1;
            tick_check();
            if (c == 2) check("restart_seli0", 32'({cs4, sl4}), 32'({1'b1, 2'd0}));
            tick_adv();
        end
        drain();

        // Asynchronous reset between edges during ACC of term 2.
        for (int c = 0; c < 10; c++) begin
            start = (c == 0); CMReady = 1'b1;
            cycle();
        end
        tick_check();
        check("rst_pre_acc2", 32'({lc4, sl4}), 32'({1'b1, 2'd2}));
        #2 rst = 1'b1;
        #1;
        check("rst_async_ready", 32'(rd4), 32'd1);
        check("rst_async_ldacc", 32'({lc4, sl4}), 32'd0);
        model_reset();
        #1 rst = 1'b0;
        start = 1'b0;
        tick_adv();
        for (int c = 0; c < 5; c++) begin
            cycle();
            check($sformatf("rst_stay_idle%0d", c), 32'({rd4, cs4, lc4}), 32'({1'b1, 2'b00}));
        end

        // Five terms with start held high: counter stops at 4, restart
        // follows the ready cycle.
        n_lc = 0; n_dn = 0; done_c = -1; max_sel = 0;
        for (int c = 0; c < 20; c++) begin
            start = 1'b1; accumulate = 1'b0; CMReady = 1'b1;
            tick_check();
            if (int'(sl5) > max_sel) max_sel = int'(sl5);
            if (lc5 && c <= 18) n_lc++;
            if (dn5 && c <= 18) begin n_dn++; done_c = c; end
            if (c == 18) check("n5_ready", 32'(rd5), 32'd1);
            if (c == 19) check("n5_reload", 32'(la5), 32'd1);
            tick_adv();
        end
        check("n5_max_seli", 32'(max_sel), 32'd4);
        check("n5_ldacc_count", 32'(n_lc), 32'd5);
        check("n5_done_count", 32'(n_dn), 32'd1);
        check("n5_done_cycle", 32'(done_c), 32'd17);
        drain();

        // Random traffic against the reference model.
        for (int c = 0; c < 2000; c++) begin
            start      = ($urandom_range(0, 3) == 0);
            accumulate = $urandom_range(0, 1) != 0;
            abort      = ($urandom_range(0, 40) == 0);
            CMReady    = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
